// File: rtl/alu_regfile_datapath.sv
// Single-cycle datapath slice: 16-entry register file, operand mux and ALU with a
// registered processor status register {N,Z,F,L,C}.
module alu_regfile_datapath #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREGS = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             WriteEnable,
    input  logic [3:0]       SelectIn,
    input  logic [3:0]       SelectA,
    input  logic [3:0]       SelectB,
    input  logic [1:0]       MuxSelect,
    input  logic [WIDTH-1:0] Immediate,
    input  logic [7:0]       OpCode,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [4:0]       PSR
);

    localparam int FlagN = 4;
    localparam int FlagZ = 3;
    localparam int FlagF = 2;
    localparam int FlagL = 1;
    localparam int FlagC = 0;

    logic [WIDTH-1:0] regFile [NREGS];
    logic [4:0]       psrQ;
    logic [4:0]       psrD;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] dst;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [4:0]       shAmt;
    logic [4:0]       shMag;

    assign A   = regFile[SelectA];
    assign B   = regFile[SelectB];
    assign dst = B;
    assign PSR = psrQ;

    always_comb begin
        unique case (MuxSelect)
            2'd0:    src = Immediate;
            2'd1:    src = A;
            2'd2:    src = B;
            default: src = '0;
        endcase
    end

    // MSB of the extended operands carries out on add and flags a borrow on subtract.
    assign sum   = {1'b0, dst} + {1'b0, src};
    assign diff  = {1'b0, dst} - {1'b0, src};
    assign shAmt = src[4:0];
    assign shMag = 5'(-shAmt);

    always_comb begin
        Result = '0;
        psrD   = psrQ;
        if (OpCode[7:4] == 4'b0000) begin
            case (OpCode[3:0])
                4'b0001: Result = dst & src;
                4'b0010: Result = dst | src;
                4'b0011: Result = dst ^ src;
                4'b0101, 4'b0110: begin
                    Result      = sum[WIDTH-1:0];
                    psrD[FlagC] = sum[WIDTH];
                    psrD[FlagZ] = (sum[WIDTH-1:0] == '0);
                    psrD[FlagN] = sum[WIDTH-1];
                    if (OpCode[3:0] == 4'b0101) begin
                        psrD[FlagF] = (dst[WIDTH-1] == src[WIDTH-1]) &&
                                      (sum[WIDTH-1] != dst[WIDTH-1]);
                    end
                end
                4'b1001: begin
                    Result      = diff[WIDTH-1:0];
                    psrD[FlagC] = diff[WIDTH];
                    psrD[FlagZ] = (diff[WIDTH-1:0] == '0);
                    psrD[FlagN] = diff[WIDTH-1];
                    psrD[FlagF] = (dst[WIDTH-1] != src[WIDTH-1]) &&
                                  (diff[WIDTH-1] != dst[WIDTH-1]);
                end
                4'b1011: begin
                    Result      = dst;
                    psrD[FlagZ] = (dst == src);
                    psrD[FlagN] = ($signed(dst) < $signed(src));
                    psrD[FlagL] = (dst < src);
                end
                4'b1101: Result = src;
                default: Result = '0;
            endcase
        end else if (OpCode == 8'b1000_0100) begin
            // Signed 5-bit amount: only -16 reaches a magnitude of 16, which clears.
            if (!shAmt[4]) begin
                Result = dst << shAmt[3:0];
            end else if (!shMag[4]) begin
                Result = dst >> shMag[3:0];
            end else begin
                Result = '0;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            psrQ <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regFile[i] <= '0;
            end
        end else begin
            psrQ <= psrD;
            if (WriteEnable) begin
                regFile[SelectIn] <= Result;
            end
        end
    end

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Directed bench for alu_regfile_datapath: hand-computed vectors checked by immediate assertions.
module tb_alu_regfile_datapath;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        WriteEnable;
    logic [3:0]  SelectIn;
    logic [3:0]  SelectA;
    logic [3:0]  SelectB;
    logic [1:0]  MuxSelect;
    logic [15:0] Immediate;
    logic [7:0]  OpCode;
    logic [15:0] Result;
    logic [15:0] A;
    logic [15:0] B;
    logic [4:0]  PSR;

    int checks   = 0;
    int failures = 0;

    alu_regfile_datapath #(.WIDTH(16), .NREGS(16)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .WriteEnable (WriteEnable),
        .SelectIn    (SelectIn),
        .SelectA     (SelectA),
        .SelectB     (SelectB),
        .MuxSelect   (MuxSelect),
        .Immediate   (Immediate),
        .OpCode      (OpCode),
        .Result      (Result),
        .A           (A),
        .B           (B),
        .PSR         (PSR)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic loadImm(input logic [3:0] r, input logic [15:0] v);
        WriteEnable = 1'b1;
        SelectIn    = r;
        MuxSelect   = 2'd0;
        Immediate   = v;
        OpCode      = 8'h0D;
        tick();
        WriteEnable = 1'b0;
    endtask

    task automatic readA(input logic [3:0] r, input string tag, input logic [15:0] exp);
        SelectA = r;
        #1;
        check(tag, A, exp);
    endtask

    initial begin
        logic [15:0] fa;
        logic [15:0] fb;
        logic [15:0] fn;
        Reset = 1'b1; WriteEnable = 1'b0; SelectIn = '0; SelectA = '0; SelectB = '0;
        MuxSelect = '0; Immediate = '0; OpCode = '0;
        tick();
        Reset = 1'b0;

        // Reset clears registers and flags, and overrides a pending write.
        loadImm(4'd5, 16'h1234);
        readA(4'd5, "r5_loaded", 16'h1234);
        SelectB = 4'd5; MuxSelect = 2'd0; Immediate = 16'h2000; OpCode = 8'h0B;
        tick();
        check("psr_before_reset", {11'd0, PSR}, 16'h0012);
        Reset = 1'b1; WriteEnable = 1'b1; SelectIn = 4'd5; OpCode = 8'h0D; Immediate = 16'h5555;
        tick();
        Reset = 1'b0; WriteEnable = 1'b0;
        readA(4'd5, "reset_r5", 16'h0000);
        check("reset_psr", {11'd0, PSR}, 16'h0000);

        loadImm(4'd0, 16'h0001);
        loadImm(4'd1, 16'h0001);
        readA(4'd0, "imm_r0", 16'h0001);
        readA(4'd1, "imm_r1", 16'h0001);

        // Fibonacci chain r[k] = r[k-2] + r[k-1].
        fa = 16'd1; fb = 16'd1;
        for (int k = 2; k < 16; k++) begin
            fn = fa + fb;
            SelectA = 4'(k - 2); SelectB = 4'(k - 1); SelectIn = 4'(k);
            MuxSelect = 2'd1; OpCode = 8'h06; WriteEnable = 1'b1;
            #1;
            check($sformatf("fib_result_%0d", k), Result, fn);
            tick();
            fa = fb; fb = fn;
        end
        WriteEnable = 1'b0;
        readA(4'd15, "fib_r15", 16'h03DB);
        check("fib_psr", {11'd0, PSR}, 16'h0000);

        // Signed overflow on ADD, then unsigned carry on ADDU with F held.
        loadImm(4'd0, 16'h7FFF);
        SelectB = 4'd0; SelectA = 4'd1; MuxSelect = 2'd1; OpCode = 8'h05;
        #1;
        check("add_ovf_result", Result, 16'h8000);
        tick();
        check("add_ovf_psr", {11'd0, PSR}, 16'h0014);
        loadImm(4'd0, 16'hFFFF);
        SelectB = 4'd0; SelectA = 4'd1; MuxSelect = 2'd1; OpCode = 8'h06;
        #1;
        check("addu_carry_result", Result, 16'h0000);
        tick();
        check("addu_carry_psr", {11'd0, PSR}, 16'h000D);

        // SUB / CMP with Dst=3, Src=5, then Dst=Src.
        loadImm(4'd2, 16'h0003);
        SelectB = 4'd2; MuxSelect = 2'd0; Immediate = 16'h0005; OpCode = 8'h09;
        #1;
        check("sub_result", Result, 16'hFFFE);
        tick();
        check("sub_psr", {11'd0, PSR}, 16'h0011);
        OpCode = 8'h0B;
        #1;
        check("cmp_result", Result, 16'h0003);
        tick();
        check("cmp_lt_psr", {11'd0, PSR}, 16'h0013);
        Immediate = 16'h0003;
        tick();
        check("cmp_eq_psr", {11'd0, PSR}, 16'h0009);

        // SUB signed overflow: 0x8000 - 1.
        loadImm(4'd3, 16'h8000);
        SelectB = 4'd3; MuxSelect = 2'd0; Immediate = 16'h0001; OpCode = 8'h09;
        #1;
        check("sub_ovf_result", Result, 16'h7FFF);
        tick();
        check("sub_ovf_psr", {11'd0, PSR}, 16'h0004);

        // Logic ops and mux sources on Dst=r2=3.
        SelectB = 4'd2; MuxSelect = 2'd0; Immediate = 16'h0006;
        OpCode = 8'h01; #1; check("and", Result, 16'h0002);
        OpCode = 8'h02; #1; check("or", Result, 16'h0007);
        OpCode = 8'h03; #1; check("xor", Result, 16'h0005);
        OpCode = 8'h0D; MuxSelect = 2'd2; #1; check("mov_src_b", Result, 16'h0003);
        MuxSelect = 2'd3; #1; check("mov_src_zero", Result, 16'h0000);

        // Shifts: left, right by -1, clear at -16, left by 15.
        OpCode = 8'h84; MuxSelect = 2'd0;
        SelectB = 4'd2; Immediate = 16'h0004; #1; check("lsh_left4", Result, 16'h0030);
        SelectB = 4'd3; Immediate = 16'h001F; #1; check("lsh_right1", Result, 16'h4000);
        Immediate = 16'h0010; #1; check("lsh_neg16", Result, 16'h0000);
        SelectB = 4'd2; Immediate = 16'h000F; #1; check("lsh_left15", Result, 16'h8000);

        // Undefined encodings produce 0 and leave flags alone.
        OpCode = 8'h85; Immediate = 16'h0004; #1; check("bad_shift_op", Result, 16'h0000);
        OpCode = 8'h07; Immediate = 16'h0001; #1; check("bad_op", Result, 16'h0000);
        tick();
        check("bad_op_psr", {11'd0, PSR}, 16'h0004);

        // WE=0 leaves the register alone.
        WriteEnable = 1'b0; SelectIn = 4'd2; MuxSelect = 2'd0; Immediate = 16'hBEEF; OpCode = 8'h0D;
        tick();
        readA(4'd2, "we0_hold", 16'h0003);

        // r2 = r2 + r2: old value until the edge, new value after.
        SelectIn = 4'd2; SelectA = 4'd2; SelectB = 4'd2; MuxSelect = 2'd1; OpCode = 8'h06;
        WriteEnable = 1'b1;
        #1;
        check("rdw_before_edge", A, 16'h0003);
        check("rdw_result", Result, 16'h0006);
        tick();
        WriteEnable = 1'b0;
        #1;
        check("rdw_after_edge", A, 16'h0006);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_regfile_datapath.md
Name: alu_regfile_datapath

Overview:
Single-cycle 16-bit datapath slice: a 16x16 register file, an operand bus mux and an ALU with a registered processor status register (PSR).
- Read ports A/B feed the mux and ALU; the ALU result is written back to the register file on the next rising clock when enabled.
- Driven by an external sequencer (for example the Fibonacci demo controller), which supplies select lines, immediate and opcode every cycle.

Parameters:
- WIDTH, 16, data width of registers, buses and ALU.
- NREGS, 16, number of registers (address width 4).

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- WriteEnable  in  1  when 1, Result is written to register SelectIn at the rising edge.
- SelectIn  in  4  write address.
- SelectA  in  4  read address, port A.
- SelectB  in  4  read address, port B.
- MuxSelect  in  2  source-operand select.
- Immediate  in  16  immediate operand.
- OpCode  in  8  [7:4] primary op, [3:0] extended op.
- Result  out  16  combinational ALU result.
- A  out  16  register[SelectA], combinational read.
- B  out  16  register[SelectB], combinational read.
- PSR  out  5  registered flags {N,Z,F,L,C} = PSR[4:0].

Behaviour:
- Reset (synchronous, active-high): all 16 registers are cleared to 0 and PSR is cleared to 0 at the rising edge. Reset overrides WriteEnable.
- Register file:
  - Reads are asynchronous.
  - A write takes effect at the edge; a same-cycle read returns the old value, with no bypass.
  - Register 0 is an ordinary writable register.
- Bus mux, producing Src:
  - MuxSelect 0 -> Immediate.
  - 1 -> A.
  - 2 -> B.
  - 3 -> 16'h0000.
- ALU operands: Src is the mux output; Dst is B. Result is combinational.
- Opcodes with OpCode[7:4] = 0000:
  - ext 0001 AND: Dst&Src.
  - ext 0010 OR: Dst|Src.
  - ext 0011 XOR: Dst^Src.
  - ext 0101 ADD: Dst+Src, sets C and F.
  - ext 0110 ADDU: Dst+Src, sets C only.
  - ext 1001 SUB: Dst-Src, sets C (borrow) and F.
  - ext 1011 CMP: Result = Dst (no change); sets Z, N (signed Dst<Src) and L (unsigned Dst<Src).
  - ext 1101 MOV: Result = Src, no flags.
- Opcodes with OpCode[7:4] = 1000 (shift):
  - ext 0100 LSH: shift Dst by signed Src[4:0]; positive = left, negative = right logical; magnitude >= 16 gives 0.
- Any other encoding: Result = 16'h0000, no flag change.
- Arithmetic is 16-bit and wraps modulo 2^16.
  - C = carry-out for add, borrow for sub.
  - F = signed overflow.
- Z and N are updated by ADD, ADDU, SUB and CMP: Z = (Result==0), N = Result[15]; for CMP, as defined above.
- PSR: the bits affected by the current opcode are loaded at each rising edge; unaffected bits hold. PSR updates regardless of WriteEnable.
- Latency:
  - Result is valid combinationally in the same cycle.
  - A written value is visible on A/B from the cycle after the write edge.
- SelectIn equal to SelectA or SelectB in the same cycle (e.g. r2 = r2 + r1): the read uses the old value and the new value is written at the edge.
- Reset asserted while WriteEnable=1: the write is discarded and the register becomes 0.

Test Plan:
- Reset: write r5=0x1234, assert Reset for 1 edge -> A (SelectA=5) = 0, PSR = 0.
- Immediate load: MuxSelect=0, Immediate=1, OpCode=0x0D, SelectIn=0, WE=1; repeat with SelectIn=1 -> A(r0)=1, A(r1)=1.
- Fibonacci chain: ADDU (0x06), MuxSelect=1, SelectA=k-2, SelectB=k-1, SelectIn=k for k=2..15 -> r15=0x03DB (987), Result matches each Fibonacci value in sequence.
- Overflow/carry: r0=0x7FFF, r1=0x0001, ADD (0x05) -> Result=0x8000, F=1, C=0, N=1. Then r0=0xFFFF, ADDU -> Result=0x0000, C=1.
- SUB/CMP: Dst=3, Src=5. SUB (0x09) -> Result=0xFFFE, C=1. CMP (0x0B) -> L=1, N=1, Z=0. With Dst=Src -> Z=1.
- WE=0 and read-during-write:
  - WE=0 with valid op -> register unchanged.
  - WE=1 with SelectIn=SelectA -> A shows the old value until the edge and the new value after it.
